dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_array.sv | 36 +++
 rtl/dmem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory arbiter slice: FSM state encoding,
// requester identifiers, default memory geometry and a small helper that
// turns a word count into an address width.
package dmem_pkg;

   localparam int DMEM_DEPTH = 2048;
   localparam int DMEM_WIDTH = 64;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef enum logic {
      REQ_M = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

   // Address width needed to index 'depth' words; never narrower than one bit
   function automatic int addr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// Single-port DEPTH x WIDTH word store with a synchronous write and a
// combinational read. Contents are never reset.
// Ports:
//   clk   - clock, writes land on the rising edge
//   we    - write enable
//   addr  - word index (already range-checked by the caller)
//   wdata - write data
//   rdata - combinational read of the word at addr
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = DMEM_DEPTH,
   parameter int WIDTH = DMEM_WIDTH,
   localparam int AW = addr_bits(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Plain storage write: the arbiter only raises we for an in-range access
   // that is actually being performed, so no further qualification is needed.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-requester arbiter in front of a single-port data memory. The pipeline
// port (m_*) and the loader/debug port (d_*) each hold a request until they
// see a one-cycle done pulse. An access takes two cycles: an IDLE cycle that
// picks a winner and registers its command, then a BUSY cycle that performs
// it and pulses the winner's done.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   m_req/m_we/m_addr/m_wdata     - pipeline command
//   m_done/m_rdata/m_err          - pipeline completion, data and range error
//   d_req/d_we/d_addr/d_wdata     - loader/debug command
//   d_done/d_rdata/d_err          - loader/debug completion, data and error
//   busy                          - high while an access is in flight
// Build option:
//   DMEM_ARB_RR_EN - when defined, simultaneous requests are resolved by a
//                    one-bit last-grant pointer (round robin); otherwise the
//                    pipeline always wins and no pointer exists.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DEPTH = DMEM_DEPTH,
   parameter int WIDTH = DMEM_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             m_req,
   input  logic             m_we,
   input  logic [63:0]      m_addr,
   input  logic [WIDTH-1:0] m_wdata,
   output logic             m_done,
   output logic [WIDTH-1:0] m_rdata,
   output logic             m_err,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [63:0]      d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic             d_done,
   output logic [WIDTH-1:0] d_rdata,
   output logic             d_err,
   output logic             busy
);

   localparam int AW = addr_bits(DEPTH);

   state_t           state;
   state_t           state_nxt;
   req_id_t          grant;
   logic             capture;
   req_id_t          cur_id;
   logic             cur_we;
   logic [63:0]      cur_addr;
   logic [WIDTH-1:0] cur_wdata;
   logic             in_range;
   logic             mem_we;
   logic [WIDTH-1:0] mem_rdata;

`ifdef DMEM_ARB_RR_EN
   req_id_t          last_grant;
`endif

   // Winner selection. A lone request always wins; a tie goes to the
   // pipeline, or with round robin to whichever port was not granted last.
   always_comb begin
      grant = REQ_M;
      if (m_req && d_req) begin
`ifdef DMEM_ARB_RR_EN
         grant = (last_grant == REQ_M) ? REQ_D : REQ_M;
`else
         grant = REQ_M;
`endif
      end else if (d_req) begin
         grant = REQ_D;
      end
   end

   assign capture = (state == IDLE) && (m_req || d_req);

   // The range check compares all 64 address bits so that large addresses
   // cannot alias onto low words by truncation.
   assign in_range = (cur_addr < 64'(DEPTH));

   // State register. Reset drops straight back to IDLE, which by itself
   // aborts an in-flight access: no done pulse and no memory write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Command register: the winner's fields are latched only in IDLE, so
   // anything on the request inputs during BUSY is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_id    <= REQ_M;
         cur_we    <= 1'b0;
         cur_addr  <= '0;
         cur_wdata <= '0;
      end else if (capture) begin
         cur_id    <= grant;
         cur_we    <= (grant == REQ_M) ? m_we : d_we;
         cur_addr  <= (grant == REQ_M) ? m_addr : d_addr;
         cur_wdata <= (grant == REQ_M) ? m_wdata : d_wdata;
      end
   end

`ifdef DMEM_ARB_RR_EN
   // Last-grant pointer. It resets to the loader port so the pipeline has
   // priority on the first tie, and moves on every grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= REQ_D;
      end else if (capture) begin
         last_grant <= grant;
      end
   end
`endif

   // Next state and all outputs. Everything the requesters see is derived
   // from the BUSY cycle only, so done, data and error are zero on the idle
   // port and whenever nothing completes.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      mem_we    = 1'b0;
      m_done    = 1'b0;
      m_rdata   = '0;
      m_err     = 1'b0;
      d_done    = 1'b0;
      d_rdata   = '0;
      d_err     = 1'b0;
      case (state)
         IDLE: begin
            if (capture) begin
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            state_nxt = IDLE;
            busy      = 1'b1;
            mem_we    = cur_we && in_range;
            if (cur_id == REQ_M) begin
               m_done  = 1'b1;
               m_err   = !in_range;
               m_rdata = (!cur_we && in_range) ? mem_rdata : '0;
            end else begin
               d_done  = 1'b1;
               d_err   = !in_range;
               d_rdata = (!cur_we && in_range) ? mem_rdata : '0;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   dmem_array #(
      .DEPTH(DEPTH),
      .WIDTH(WIDTH)
   ) u_array (
      .clk  (clk),
      .we   (mem_we),
      .addr (cur_addr[AW-1:0]),
      .wdata(cur_wdata),
      .rdata(mem_rdata)
   );

endmodule
